hub75_scan_bcm: RTL and testbench
=================================

Name: hub75_scan_bcm

Overview:
- Parametrised row-scan and binary-code-modulation (BCM) sequencer for HUB75 panels. Next generation of the fixed-geometry scan logic in the panel top level.
- Drives panel row address, latch and blank directly.
- Handshakes with the column shifter: one shift request per row/plane; plane-weighted on-time.
- Adds a run/stop control, a frame-done strobe, and an optional global-brightness stage.

Parameters:
- N_ROWS, 32, scanned rows per bank; power of two, 2..64.
- N_PLANES, 8, BCM bit planes, 1..10.
- ROW_W, $clog2(N_ROWS), address width (derived, not overridden).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  async active-low reset.
- run  in  1  level; 1 = scan continuously.
- cfg_pre_latch_len  in  8  blank-before-latch cycles, minus 1.
- cfg_latch_len  in  8  latch pulse cycles, minus 1.
- cfg_post_latch_len  in  8  blank-after-latch cycles, minus 1.
- cfg_bcm_bit_len  in  8  LSB-plane on-time, minus 1.
- cfg_brightness  in  8  global brightness; only with HUB75_BRIGHTNESS_EN.
- shift_req  out  1  request shifter to load shift_row/shift_plane.
- shift_row  out  ROW_W  row to shift.
- shift_plane  out  $clog2(N_PLANES) (min 1)  plane to shift.
- shift_done  in  1  one-cycle pulse: shifter finished.
- hub75_addr  out  ROW_W  panel row address.
- hub75_le  out  1  latch enable.
- hub75_blank  out  1  1 = LEDs off.
- frame_done  out  1  one-cycle pulse after the last row/plane on-period.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; row=0, plane=0, counters=0.
  - shift_req=0, hub75_le=0, hub75_blank=1, hub75_addr=0, frame_done=0.
- All cfg_* inputs are sampled into shadow registers on entry to PRE. They stay stable for that plane.
- States:
  - IDLE: blank=1. If run=1, go to SHIFT next cycle.
  - SHIFT: shift_req=1 for exactly one cycle, with shift_row/shift_plane valid. Go to WAIT.
  - WAIT: shift_req=0; hold until shift_done. A shift_done seen in any other state is ignored.
  - PRE: blank=1 for cfg_pre_latch_len+1 cycles.
  - LATCH: le=1, blank=1 for cfg_latch_len+1 cycles. hub75_addr updates to the current row on the first LATCH cycle.
  - POST: blank=1 for cfg_post_latch_len+1 cycles.
  - ON: blank=0 for L = (cfg_bcm_bit_len+1) << plane cycles. The counter is 8+N_PLANES bits wide; L never wraps.
  - NEXT: blank=1 for one cycle, then:
    - plane<N_PLANES-1: plane++.
    - Otherwise: plane=0; row++ with wrap N_ROWS-1 → 0. On that wrap, frame_done pulses this cycle.
    - If run=1, go to SHIFT; else go to IDLE.
- run deasserted mid-plane: the current plane completes through NEXT, then IDLE. There is no truncated on-time.
- On NEXT→IDLE, row and plane are retained; a later run=1 resumes at the next row/plane.
- Simultaneous shift_done and state entry to WAIT (same cycle as SHIFT): shift_done is ignored. The shifter must answer at least one cycle after shift_req.
- Every output is a registered state decode with no combinational path from inputs. Latency from run rising in IDLE to shift_req is 1 cycle.
- hub75_le and hub75_blank=0 are never asserted together.

Optional Feature:
- Macro: HUB75_BRIGHTNESS_EN.
- Defined:
  - In ON, blank=0 only while cnt < Lb, where Lb = (L * (cfg_brightness+1)) >> 8. Use an unsigned multiply registered in PRE.
  - blank=1 for the remaining L-Lb cycles; ON total duration is still L.
  - If Lb=0, blank stays 1 for the whole ON period.
- Undefined: the cfg_brightness port is still present but ignored; blank=0 for all L cycles.

Test Plan:
- N_ROWS=4, N_PLANES=2, pre=latch=post=1, bcm=3, shift_done 2 cycles after each req:
  - ON lengths alternate 4, 8.
  - Sequence row0p0, row0p1, row1p0, …
  - frame_done pulses once after row3p1.
  - hub75_addr goes 0,1,2,3,0.
- Reset asserted during ON of row2p1 → outputs immediately blank=1, le=0, addr=0, shift_req=0. After release with run=1, the first shift_req carries row0 plane0.
- run dropped in LATCH of row1p0 → le/post/ON complete with ON=4 cycles, then IDLE with blank=1. run=1 resumes with shift_req for row1p1.
- shift_done pulse injected during ON → no effect on timing; the count of shift_req per frame is exactly N_ROWS*N_PLANES=8.
- bcm=255, N_PLANES=8, plane 7 → ON = 32768 cycles exactly, with no counter wrap.
- HUB75_BRIGHTNESS_EN, bcm=3, plane=1, cfg_brightness=127:
  - blank=0 for 4 cycles, then blank=1 for 4 cycles.
  - cfg_brightness=0 gives Lb=0, so blank stays 1 throughout.

Source files
------------

// File: rtl/hub75_scan_bcm.sv
// HUB75 row-scan / binary-code-modulation sequencer with column-shifter handshake.
// Define HUB75_BRIGHTNESS_EN to scale each plane's lit time by cfg_brightness.
module hub75_scan_bcm #(
  parameter int N_ROWS   = 32,
  parameter int N_PLANES = 8,
  parameter int ROW_W    = $clog2(N_ROWS),
  parameter int PLANE_W  = (N_PLANES > 1) ? $clog2(N_PLANES) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  input  logic [7:0]         cfg_pre_latch_len,
  input  logic [7:0]         cfg_latch_len,
  input  logic [7:0]         cfg_post_latch_len,
  input  logic [7:0]         cfg_bcm_bit_len,
  input  logic [7:0]         cfg_brightness,
  output logic               shift_req,
  output logic [ROW_W-1:0]   shift_row,
  output logic [PLANE_W-1:0] shift_plane,
  input  logic               shift_done,
  output logic [ROW_W-1:0]   hub75_addr,
  output logic               hub75_le,
  output logic               hub75_blank,
  output logic               frame_done
);

  localparam int CW = 8 + N_PLANES;
  localparam int PW = CW + 9;

  typedef enum logic [2:0] {
    S_IDLE, S_SHIFT, S_WAIT, S_PRE, S_LATCH, S_POST, S_ON, S_NEXT
  } state_e;

  state_e               state_q, state_d;
  logic [ROW_W-1:0]     row_q, row_d;
  logic [PLANE_W-1:0]   plane_q, plane_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [7:0]           pre_q, pre_d;
  logic [7:0]           latch_q, latch_d;
  logic [7:0]           post_q, post_d;
  logic [7:0]           bcm_q, bcm_d;
  logic [CW-1:0]        on_len_q, on_len_d;
  logic [CW-1:0]        lb_q, lb_d;
  logic [ROW_W-1:0]     addr_q, addr_d;
  logic                 shift_req_q, shift_req_d;
  logic                 le_q, le_d;
  logic                 blank_q, blank_d;
  logic                 frame_done_q, frame_done_d;

  logic [CW-1:0]        on_len_calc;
  logic [CW-1:0]        lb_calc;
  logic                 last_row;
  logic                 last_plane;

  assign on_len_calc = (CW'(bcm_q) + CW'(1)) << plane_q;
  assign last_row    = (row_q == ROW_W'(N_ROWS - 1));
  assign last_plane  = (plane_q == PLANE_W'(N_PLANES - 1));

`ifdef HUB75_BRIGHTNESS_EN
  logic [7:0]    bri_q, bri_d;
  logic [PW-1:0] bri_prod;

  assign bri_prod = PW'(on_len_calc) * PW'({1'b0, bri_q} + 9'd1);
  assign lb_calc  = CW'(bri_prod >> 8);
`else
  logic unused_brightness;

  assign unused_brightness = ^cfg_brightness;
  assign lb_calc           = on_len_calc;
`endif

  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    plane_d      = plane_q;
    cnt_d        = cnt_q;
    pre_d        = pre_q;
    latch_d      = latch_q;
    post_d       = post_q;
    bcm_d        = bcm_q;
    on_len_d     = on_len_q;
    lb_d         = lb_q;
    addr_d       = addr_q;
    shift_req_d  = 1'b0;
    le_d         = 1'b0;
    blank_d      = 1'b1;
    frame_done_d = 1'b0;
`ifdef HUB75_BRIGHTNESS_EN
    bri_d        = bri_q;
`endif
    // Outputs are decoded from the state being entered, so they are registered.
    case (state_q)
      S_IDLE: begin
        if (run) begin
          state_d     = S_SHIFT;
          shift_req_d = 1'b1;
        end
      end
      S_SHIFT: state_d = S_WAIT;
      S_WAIT: begin
        if (shift_done) begin
          state_d = S_PRE;
          cnt_d   = '0;
          pre_d   = cfg_pre_latch_len;
          latch_d = cfg_latch_len;
          post_d  = cfg_post_latch_len;
          bcm_d   = cfg_bcm_bit_len;
`ifdef HUB75_BRIGHTNESS_EN
          bri_d   = cfg_brightness;
`endif
        end
      end
      S_PRE: begin
        on_len_d = on_len_calc;
        lb_d     = lb_calc;
        if (cnt_q == CW'(pre_q)) begin
          state_d = S_LATCH;
          cnt_d   = '0;
          le_d    = 1'b1;
          addr_d  = row_q;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_LATCH: begin
        if (cnt_q == CW'(latch_q)) begin
          state_d = S_POST;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
          le_d  = 1'b1;
        end
      end
      S_POST: begin
        if (cnt_q == CW'(post_q)) begin
          state_d = S_ON;
          cnt_d   = '0;
          blank_d = (lb_q == '0);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_ON: begin
        if (cnt_q == on_len_q - CW'(1)) begin
          state_d      = S_NEXT;
          frame_done_d = last_row && last_plane;
        end else begin
          cnt_d   = cnt_q + CW'(1);
          blank_d = !((cnt_q + CW'(1)) < lb_q);
        end
      end
      S_NEXT: begin
        if (last_plane) begin
          plane_d = '0;
          row_d   = row_q + ROW_W'(1);
        end else begin
          plane_d = plane_q + PLANE_W'(1);
        end
        if (run) begin
          state_d     = S_SHIFT;
          shift_req_d = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      row_q        <= '0;
      plane_q      <= '0;
      cnt_q        <= '0;
      pre_q        <= '0;
      latch_q      <= '0;
      post_q       <= '0;
      bcm_q        <= '0;
      on_len_q     <= '0;
      lb_q         <= '0;
      addr_q       <= '0;
      shift_req_q  <= 1'b0;
      le_q         <= 1'b0;
      blank_q      <= 1'b1;
      frame_done_q <= 1'b0;
`ifdef HUB75_BRIGHTNESS_EN
      bri_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      plane_q      <= plane_d;
      cnt_q        <= cnt_d;
      pre_q        <= pre_d;
      latch_q      <= latch_d;
      post_q       <= post_d;
      bcm_q        <= bcm_d;
      on_len_q     <= on_len_d;
      lb_q         <= lb_d;
      addr_q       <= addr_d;
      shift_req_q  <= shift_req_d;
      le_q         <= le_d;
      blank_q      <= blank_d;
      frame_done_q <= frame_done_d;
`ifdef HUB75_BRIGHTNESS_EN
      bri_q        <= bri_d;
`endif
    end
  end

  assign shift_req   = shift_req_q;
  assign shift_row   = row_q;
  assign shift_plane = plane_q;
  assign hub75_addr  = addr_q;
  assign hub75_le    = le_q;
  assign hub75_blank = blank_q;
  assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_hub75_scan_bcm.sv
`timescale 1ns/1ps
// Bench for hub75_scan_bcm: 4-row/2-plane scan sequence checks plus an 8-plane instance for the longest on-time.
// Add +define+HUB75_BRIGHTNESS_EN to check the brightness stage as well.
module tb_hub75_scan_bcm;
  localparam int CFG_STAGE = 1;
  localparam int BCM       = 3;
  localparam int ON_START  = 2 + 3 * (CFG_STAGE + 1);
`ifdef HUB75_BRIGHTNESS_EN
  localparam bit BRI_EN = 1'b1;
`else
  localparam bit BRI_EN = 1'b0;
`endif

  typedef struct { int row; int plane; int len; int lb; bit fd; } slot_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run = 1'b0;
  logic [7:0] cfg_pre = 8'(CFG_STAGE), cfg_latch = 8'(CFG_STAGE), cfg_post = 8'(CFG_STAGE);
  logic [7:0] cfg_bcm = 8'(BCM), cfg_bri = 8'd255;
  logic       shift_req;
  logic [1:0] shift_row;
  logic [0:0] shift_plane;
  logic       ack_done = 1'b0, inj_done = 1'b0;
  logic [1:0] hub75_addr;
  logic       le, blank, frame_done;

  logic       b_run = 1'b0;
  logic [7:0] b_bcm = 8'd0, b_bri = 8'd255, b_zero = 8'd0;
  logic       b_shift_req;
  logic [0:0] b_shift_row;
  logic [2:0] b_shift_plane;
  logic       b_ack_done = 1'b0;
  logic [0:0] b_addr;
  logic       b_le, b_blank, b_frame_done;

  int    n_tests = 0, n_fail = 0, req_cnt = 0;
  bit    ack_en = 1'b1;
  slot_t exp_q[$];

  hub75_scan_bcm #(.N_ROWS(4), .N_PLANES(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .cfg_pre_latch_len(cfg_pre), .cfg_latch_len(cfg_latch), .cfg_post_latch_len(cfg_post),
    .cfg_bcm_bit_len(cfg_bcm), .cfg_brightness(cfg_bri),
    .shift_req(shift_req), .shift_row(shift_row), .shift_plane(shift_plane),
    .shift_done(ack_done | inj_done),
    .hub75_addr(hub75_addr), .hub75_le(le), .hub75_blank(blank), .frame_done(frame_done)
  );

  hub75_scan_bcm #(.N_ROWS(2), .N_PLANES(8)) u_big (
    .clk(clk), .rst_n(rst_n), .run(b_run),
    .cfg_pre_latch_len(b_zero), .cfg_latch_len(b_zero), .cfg_post_latch_len(b_zero),
    .cfg_bcm_bit_len(b_bcm), .cfg_brightness(b_bri),
    .shift_req(b_shift_req), .shift_row(b_shift_row), .shift_plane(b_shift_plane),
    .shift_done(b_ack_done),
    .hub75_addr(b_addr), .hub75_le(b_le), .hub75_blank(b_blank), .frame_done(b_frame_done)
  );

  always #5 clk = ~clk;

  // Shifter model: answers two cycles after each request.
  always @(negedge clk) begin
    if (ack_en && shift_req) begin
      @(posedge clk); #1 ack_done = 1'b1;
      @(posedge clk); #1 ack_done = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (b_shift_req) begin
      @(posedge clk); #1 b_ack_done = 1'b1;
      @(posedge clk); #1 b_ack_done = 1'b0;
    end
  end

  always @(negedge clk) if (shift_req) req_cnt++;

  function automatic slot_t mk_slot(int r, int p, int bcm, int bri, int nr, int np);
    slot_t s;
    s.row   = r;
    s.plane = p;
    s.len   = (bcm + 1) << p;
    s.lb    = BRI_EN ? ((s.len * (bri + 1)) >> 8) : s.len;
    s.fd    = (r == nr - 1) && (p == np - 1);
    return s;
  endfunction

  task automatic do_reset();
    run = 1'b0; b_run = 1'b0; ack_en = 1'b1; inj_done = 1'b0;
    @(negedge clk); rst_n = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (shift_req) begin ok = 1'b1; break; end
    end
  endtask

  // Observes one slot starting at its shift_req sample; ends at the next shift_req or after 400 cycles.
  task automatic measure_slot(input bit inject, output int period, output int low, output int first_low,
                              output int last_low, output int le_n, output int le_addr, output int fd_off,
                              output int bad);
    bit inj = 1'b0;
    period = -1; low = 0; first_low = -1; last_low = -1; le_n = 0; le_addr = -1; fd_off = -1; bad = 0;
    for (int off = 1; off < 400; off++) begin
      @(negedge clk);
      if (inj) begin inj_done = 1'b0; inj = 1'b0; end
      if (shift_req) begin period = off; break; end
      if (!blank) begin
        low++;
        if (first_low < 0) begin
          first_low = off;
          if (inject) begin inj_done = 1'b1; inj = 1'b1; end
        end
        last_low = off;
      end
      if (le) begin
        if (le_addr < 0) le_addr = int'(hub75_addr);
        le_n++;
        if (!blank) bad++;
      end
      if (frame_done) fd_off = off;
    end
    inj_done = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; run = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++; if (shift_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", shift_req); end
    n_tests++; if (le !== 1'b0) begin n_fail++; $display("FAIL reset_le: got %b want 0", le); end
    n_tests++; if (blank !== 1'b1) begin n_fail++; $display("FAIL reset_blank: got %b want 1", blank); end
    n_tests++; if (hub75_addr !== 2'd0) begin n_fail++; $display("FAIL reset_addr: got %0d want 0", hub75_addr); end
    n_tests++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_fd: got %b want 0", frame_done); end
    n_tests++; if (b_blank !== 1'b1 || b_shift_req !== 1'b0) begin
      n_fail++; $display("FAIL reset_big: blank %b req %b want 1 0", b_blank, b_shift_req);
    end
  endtask

  task automatic test_frame();
    slot_t e;
    int per, low, fl, ll, len_le, la, fdo, bad;
    do_reset();
    cfg_bri = 8'd255;
    exp_q.delete();
    for (int i = 0; i < 9; i++) exp_q.push_back(mk_slot((i / 2) % 4, i % 2, BCM, 255, 4, 2));
    run = 1'b1;
    @(negedge clk);
    n_tests++; if (shift_req !== 1'b1) begin n_fail++; $display("FAIL req_latency: got %b want 1", shift_req); end
    for (int i = 0; i < 9; i++) begin
      e = exp_q.pop_front();
      n_tests++;
      if (int'(shift_row) !== e.row || int'(shift_plane) !== e.plane) begin
        n_fail++; $display("FAIL frame_req%0d: got r%0d p%0d want r%0d p%0d", i, shift_row, shift_plane, e.row, e.plane);
      end
      measure_slot(1'b0, per, low, fl, ll, len_le, la, fdo, bad);
      n_tests++;
      if (low !== e.lb || fl !== ON_START || per !== ON_START + e.len + 1) begin
        n_fail++; $display("FAIL frame_on%0d: low %0d start %0d period %0d want %0d %0d %0d",
                           i, low, fl, per, e.lb, ON_START, ON_START + e.len + 1);
      end
      n_tests++;
      if (la !== e.row || len_le !== CFG_STAGE + 1 || bad !== 0) begin
        n_fail++; $display("FAIL frame_latch%0d: addr %0d le %0d overlap %0d want %0d %0d 0",
                           i, la, len_le, bad, e.row, CFG_STAGE + 1);
      end
      n_tests++;
      if (fdo !== (e.fd ? ON_START + e.len : -1)) begin
        n_fail++; $display("FAIL frame_done%0d: offset %0d want %0d", i, fdo, e.fd ? ON_START + e.len : -1);
      end
    end
    run = 1'b0;
    repeat (40) @(negedge clk);
  endtask

  task automatic test_reset_mid_on();
    slot_t e;
    bit ok;
    int per, low, fl, ll, len_le, la, fdo, bad;
    do_reset();
    exp_q.delete();
    for (int i = 0; i < 6; i++) exp_q.push_back(mk_slot((i / 2) % 4, i % 2, BCM, 255, 4, 2));
    run = 1'b1;
    wait_req(ok);
    for (int i = 0; i < 5; i++) begin
      e = exp_q.pop_front();
      measure_slot(1'b0, per, low, fl, ll, len_le, la, fdo, bad);
    end
    e = exp_q.pop_front();
    n_tests++;
    if (!ok || int'(shift_row) !== e.row || int'(shift_plane) !== e.plane) begin
      n_fail++; $display("FAIL rst_slot: got r%0d p%0d want r%0d p%0d", shift_row, shift_plane, e.row, e.plane);
    end
    ok = 1'b0;
    for (int c = 0; c < 50; c++) begin @(negedge clk); if (!blank) begin ok = 1'b1; break; end end
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (!ok || blank !== 1'b1 || le !== 1'b0 || hub75_addr !== 2'd0 || shift_req !== 1'b0) begin
      n_fail++; $display("FAIL rst_async: on %b blank %b le %b addr %0d req %b want 1 1 0 0 0",
                         ok, blank, le, hub75_addr, shift_req);
    end
    @(negedge clk); rst_n = 1'b1;
    exp_q.push_back(mk_slot(0, 0, BCM, 255, 4, 2));
    wait_req(ok);
    e = exp_q.pop_front();
    n_tests++;
    if (!ok || int'(shift_row) !== e.row || int'(shift_plane) !== e.plane) begin
      n_fail++; $display("FAIL rst_resume: got r%0d p%0d want r%0d p%0d", shift_row, shift_plane, e.row, e.plane);
    end
    run = 1'b0;
    repeat (40) @(negedge clk);
  endtask

  task automatic test_run_stop();
    slot_t e;
    bit ok;
    int per, low, fl, ll, len_le, la, fdo, bad, reqs;
    do_reset();
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(mk_slot((i / 2) % 4, i % 2, BCM, 255, 4, 2));
    run = 1'b1;
    wait_req(ok);
    for (int i = 0; i < 2; i++) begin
      e = exp_q.pop_front();
      measure_slot(1'b0, per, low, fl, ll, len_le, la, fdo, bad);
    end
    e = exp_q.pop_front();
    n_tests++;
    if (!ok || int'(shift_row) !== e.row || int'(shift_plane) !== e.plane) begin
      n_fail++; $display("FAIL stop_slot: got r%0d p%0d want r%0d p%0d", shift_row, shift_plane, e.row, e.plane);
    end
    ok = 1'b0;
    for (int c = 0; c < 50; c++) begin @(negedge clk); if (le) begin ok = 1'b1; break; end end
    run = 1'b0;
    low = 0; reqs = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (!blank) low++;
      if (shift_req) reqs++;
    end
    n_tests++;
    if (!ok || low !== e.lb || reqs !== 0 || blank !== 1'b1) begin
      n_fail++; $display("FAIL stop_drain: le %b low %0d reqs %0d blank %b want 1 %0d 0 1", ok, low, reqs, blank, e.lb);
    end
    e = exp_q.pop_front();
    run = 1'b1;
    @(negedge clk);
    n_tests++;
    if (shift_req !== 1'b1 || int'(shift_row) !== e.row || int'(shift_plane) !== e.plane) begin
      n_fail++; $display("FAIL stop_resume: req %b r%0d p%0d want 1 r%0d p%0d", shift_req, shift_row, shift_plane, e.row, e.plane);
    end
    run = 1'b0;
    repeat (40) @(negedge clk);
  endtask

  task automatic test_spurious_done();
    slot_t e;
    bit ok;
    int per, low, fl, ll, len_le, la, fdo, bad, stray, base;
    do_reset();
    base = req_cnt;
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(mk_slot((i / 2) % 4, i % 2, BCM, 255, 4, 2));
    ack_en = 1'b0;
    run = 1'b1;
    wait_req(ok);
    inj_done = 1'b1;
    @(negedge clk); inj_done = 1'b0;
    stray = 0;
    for (int c = 0; c < 6; c++) begin @(negedge clk); if (le || !blank) stray++; end
    n_tests++;
    if (!ok || stray !== 0) begin n_fail++; $display("FAIL done_in_shift: req %b stray %0d want 1 0", ok, stray); end
    inj_done = 1'b1;
    @(negedge clk); inj_done = 1'b0; ack_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      e = exp_q.pop_front();
      if (i > 0) begin
        n_tests++;
        if (int'(shift_row) !== e.row || int'(shift_plane) !== e.plane) begin
          n_fail++; $display("FAIL spur_req%0d: got r%0d p%0d want r%0d p%0d", i, shift_row, shift_plane, e.row, e.plane);
        end
      end
      if (i == 7) run = 1'b0;
      measure_slot(1'b1, per, low, fl, ll, len_le, la, fdo, bad);
      n_tests++;
      if (low !== e.lb || (i > 0 && i < 7 && per !== ON_START + e.len + 1)) begin
        n_fail++; $display("FAIL spur_on%0d: low %0d period %0d want %0d %0d", i, low, per, e.lb, ON_START + e.len + 1);
      end
    end
    n_tests++;
    if (req_cnt - base !== 8) begin n_fail++; $display("FAIL spur_req_count: got %0d want 8", req_cnt - base); end
  endtask

  task automatic test_brightness();
    slot_t e;
    bit ok;
    int per, low, fl, ll, len_le, la, fdo, bad;
    do_reset();
    cfg_bri = 8'd127;
    exp_q.delete();
    exp_q.push_back(mk_slot(0, 0, BCM, 127, 4, 2));
    exp_q.push_back(mk_slot(0, 1, BCM, 127, 4, 2));
    exp_q.push_back(mk_slot(1, 0, BCM, 0, 4, 2));
    exp_q.push_back(mk_slot(1, 1, BCM, 0, 4, 2));
    run = 1'b1;
    wait_req(ok);
    for (int i = 0; i < 4; i++) begin
      e = exp_q.pop_front();
      if (i == 2) cfg_bri = 8'd0;
      measure_slot(1'b0, per, low, fl, ll, len_le, la, fdo, bad);
      n_tests++;
      if (low !== e.lb || per !== ON_START + e.len + 1 ||
          fl !== (e.lb > 0 ? ON_START : -1) || ll !== (e.lb > 0 ? ON_START + e.lb - 1 : -1)) begin
        n_fail++; $display("FAIL bright%0d: low %0d first %0d last %0d period %0d want low %0d period %0d",
                           i, low, fl, ll, per, e.lb, ON_START + e.len + 1);
      end
    end
    run = 1'b0;
    cfg_bri = 8'd255;
    repeat (40) @(negedge clk);
  endtask

  task automatic test_long_plane();
    slot_t e;
    bit ok;
    int low;
    do_reset();
    b_bcm = 8'd0;
    exp_q.delete();
    for (int p = 0; p < 8; p++) exp_q.push_back(mk_slot(0, p, (p == 7) ? 255 : 0, 255, 2, 8));
    b_run = 1'b1;
    for (int p = 0; p < 8; p++) begin
      e = exp_q.pop_front();
      ok = 1'b0;
      for (int c = 0; c < 200; c++) begin @(negedge clk); if (b_shift_req) begin ok = 1'b1; break; end end
      n_tests++;
      if (!ok || int'(b_shift_row) !== e.row || int'(b_shift_plane) !== e.plane) begin
        n_fail++; $display("FAIL long_req%0d: got r%0d p%0d want r%0d p%0d", p, b_shift_row, b_shift_plane, e.row, e.plane);
      end
      if (p == 7) begin b_bcm = 8'd255; b_run = 1'b0; end
      ok = 1'b0;
      for (int c = 0; c < 50; c++) begin @(negedge clk); if (!b_blank) begin ok = 1'b1; break; end end
      low = 0;
      for (int c = 0; c < 40000 && ok && !b_blank; c++) begin low++; @(negedge clk); end
      n_tests++;
      if (low !== e.len) begin n_fail++; $display("FAIL long_on%0d: got %0d want %0d", p, low, e.len); end
    end
    repeat (10) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_frame();
    test_reset_mid_on();
    test_run_stop();
    test_spurious_done();
    test_brightness();
    test_long_plane();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
